// File: rtl/la_strapctrl_pkg.sv
// Shared types and width helpers for the strap configuration controller.
package la_strapctrl_pkg;

  typedef enum logic [1:0] {
    ST_SETTLE  = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_CHECK   = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  function automatic int settle_cnt_w(input int settle);
    return $clog2(settle + 1);
  endfunction

  function automatic int retry_cnt_w(input int retry);
    return $clog2(retry + 1);
  endfunction

endpackage

// File: rtl/la_strapctrl_settle.sv
// Settle-wait counter: counts up while enabled, holds at SETTLE-1 and flags done.
module la_strapctrl_settle
  import la_strapctrl_pkg::*;
#(
  parameter int SETTLE = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_done
);

  localparam int CW = settle_cnt_w(SETTLE);
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_en && !o_done) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_done = (r_count == LAST);

endmodule

// File: rtl/la_strapctrl.sv
// Strap configuration controller: settle, double-sample, publish, then allow
// software overrides until a sticky lock is set.
//
// state   | meaning
// SETTLE  | waiting for straps to settle before a sample attempt
// CAPTURE | first sample taken into the shadow register
// CHECK   | second sample compared against the shadow
// RUN     | configuration published; overrides/lock handled
module la_strapctrl
  import la_strapctrl_pkg::*;
#(
  parameter int    N      = 8,
  parameter int    SETTLE = 4,
  parameter int    RETRY  = 3,
  parameter string PROP   = "DEFAULT"
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_strap_in,
  input  logic         i_cfg_wen,
  input  logic [N-1:0] i_cfg_wdata,
  input  logic         i_cfg_lock,
  output logic [N-1:0] o_cfg_out,
  output logic         o_valid,
  output logic         o_cfg_wack,
  output logic         o_locked,
  output logic         o_strap_err
);

  localparam int RW = retry_cnt_w(RETRY);
  localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY - 1);

  state_e       r_state, w_state_nxt;
  logic [N-1:0] r_shadow;
  logic [RW-1:0] r_retry;
  logic         w_settle_done;
  logic         w_match;
  logic         w_last_try;
  logic         w_wr_ok;
  logic [N-1:0] w_cfg_nxt;
  logic         w_valid_nxt, w_wack_nxt, w_locked_nxt, w_err_nxt;

  assign w_match    = (i_strap_in == r_shadow);
  assign w_last_try = (r_retry == RETRY_LAST);
  assign w_wr_ok    = (r_state == ST_RUN) && i_cfg_wen && !o_locked;

  la_strapctrl_settle #(.SETTLE(SETTLE)) u_settle (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear ((r_state == ST_SETTLE) && w_settle_done),
    .i_en    (r_state == ST_SETTLE),
    .o_done  (w_settle_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_SETTLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SETTLE:  if (w_settle_done) w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: w_state_nxt = ST_CHECK;
      ST_CHECK:   w_state_nxt = (w_match || w_last_try) ? ST_RUN : ST_SETTLE;
      default:    w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_cfg_nxt    = o_cfg_out;
    w_valid_nxt  = o_valid;
    w_wack_nxt   = 1'b0;
    w_locked_nxt = o_locked;
    w_err_nxt    = o_strap_err;
    case (r_state)
      ST_CHECK: begin
        if (w_match) begin
          w_cfg_nxt   = r_shadow;
          w_valid_nxt = 1'b1;
        end else if (w_last_try) begin
          w_cfg_nxt   = i_strap_in;
          w_valid_nxt = 1'b1;
          w_err_nxt   = 1'b1;
        end
      end
      ST_RUN: begin
        // A write in the same cycle as lock still lands; lock gates the next one.
        if (w_wr_ok) begin
          w_cfg_nxt  = i_cfg_wdata;
          w_wack_nxt = 1'b1;
        end
        if (i_cfg_lock) w_locked_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shadow    <= '0;
      r_retry     <= '0;
      o_cfg_out   <= '0;
      o_valid     <= 1'b0;
      o_cfg_wack  <= 1'b0;
      o_locked    <= 1'b0;
      o_strap_err <= 1'b0;
    end else begin
      if (r_state == ST_CAPTURE) r_shadow <= i_strap_in;
      if (r_state == ST_CHECK) begin
        if (w_match || w_last_try) r_retry <= '0;
        else                       r_retry <= r_retry + RW'(1);
      end
      o_cfg_out   <= w_cfg_nxt;
      o_valid     <= w_valid_nxt;
      o_cfg_wack  <= w_wack_nxt;
      o_locked    <= w_locked_nxt;
      o_strap_err <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_la_strapctrl.sv
// Self-checking bench for la_strapctrl: strap sampling, retries, forced accept,
// overrides with a write scoreboard, lock and mid-operation reset.
module tb_la_strapctrl;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_strap_in;
  logic       i_cfg_wen;
  logic [7:0] i_cfg_wdata;
  logic       i_cfg_lock;
  logic [7:0] o_cfg_out;
  logic       o_valid;
  logic       o_cfg_wack;
  logic       o_locked;
  logic       o_strap_err;

  int total = 0;
  int bad   = 0;
  int wack_cnt = 0;
  logic [7:0] exp_q[$];

  la_strapctrl #(.N(8), .SETTLE(4), .RETRY(3), .PROP("DEFAULT")) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_strap_in  (i_strap_in),
    .i_cfg_wen   (i_cfg_wen),
    .i_cfg_wdata (i_cfg_wdata),
    .i_cfg_lock  (i_cfg_lock),
    .o_cfg_out   (o_cfg_out),
    .o_valid     (o_valid),
    .o_cfg_wack  (o_cfg_wack),
    .o_locked    (o_locked),
    .o_strap_err (o_strap_err)
  );

  always #5 i_clk = ~i_clk;

  // Write scoreboard: every accepted write must show its data alongside cfg_wack.
  always @(negedge i_clk) begin
    if (o_cfg_wack) begin
      wack_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wack_unexpected: cfg_wack=1 cfg_out=%h, no write expected", o_cfg_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (o_cfg_out !== e) begin
          bad++;
          $display("FAIL wack_data: cfg_out=%h expected=%h", o_cfg_out, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic check_zero(input string name);
    total++;
    if ({o_cfg_out, o_valid, o_cfg_wack, o_locked, o_strap_err} !== 12'h000) begin
      bad++;
      $display("FAIL %s: cfg_out=%h valid=%b wack=%b locked=%b err=%b expected all 0",
               name, o_cfg_out, o_valid, o_cfg_wack, o_locked, o_strap_err);
    end
  endtask

  function automatic logic [7:0] strap_for(input int mode, input logic [7:0] base, input int e);
    if (mode == 1) return (e == 4) ? 8'h00 : base;
    if (mode == 2) return e[0] ? 8'hAA : 8'h55;
    return base;
  endfunction

  // Release reset and count edges until valid; edge 0 is the first with rst=0.
  task automatic release_and_wait(input int mode, input logic [7:0] base, input bit early,
                                  input int exp_edges, input logic [7:0] exp_cfg,
                                  input logic exp_err, input string name);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    i_rst = 1'b0;
    i_cfg_wen   = early;
    i_cfg_wdata = 8'hFF;
    i_cfg_lock  = early;
    for (int e = 0; e < 40 && !seen; e++) begin
      i_strap_in = strap_for(mode, base, e);
      step();
      n = e + 1;
      if (o_valid) seen = 1;
    end
    i_cfg_wen  = 1'b0;
    i_cfg_lock = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_timeout: valid never rose within 40 cycles", name);
    end else if (n != exp_edges) begin
      bad++;
      $display("FAIL %s_latency: valid after %0d edges expected %0d", name, n, exp_edges);
    end
    total++;
    if (o_cfg_out !== exp_cfg) begin
      bad++;
      $display("FAIL %s_cfg: cfg_out=%h expected=%h", name, o_cfg_out, exp_cfg);
    end
    total++;
    if (o_strap_err !== exp_err || o_locked !== 1'b0) begin
      bad++;
      $display("FAIL %s_flags: strap_err=%b locked=%b expected err=%b locked=0",
               name, o_strap_err, o_locked, exp_err);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_strap_in = 8'hA5;
    i_cfg_wen = 1'b0;
    i_cfg_wdata = 8'h00;
    i_cfg_lock = 1'b0;
    step();
    step();
    check_zero("reset_values");
  endtask

  task automatic test_stable();
    release_and_wait(0, 8'hA5, 1'b0, 6, 8'hA5, 1'b0, "stable");
  endtask

  task automatic test_glitch();
    i_rst = 1'b1;
    step();
    check_zero("glitch_reset");
    release_and_wait(1, 8'h3C, 1'b0, 12, 8'h3C, 1'b0, "glitch");
  endtask

  task automatic test_forced();
    i_rst = 1'b1;
    step();
    release_and_wait(2, 8'h00, 1'b0, 18, 8'hAA, 1'b1, "forced");
  endtask

  task automatic test_early_access();
    int w0;
    i_rst = 1'b1;
    step();
    w0 = wack_cnt;
    release_and_wait(0, 8'hA5, 1'b1, 6, 8'hA5, 1'b0, "early");
    step();
    step();
    total++;
    if (o_cfg_out !== 8'hA5 || o_locked !== 1'b0 || wack_cnt != w0) begin
      bad++;
      $display("FAIL early_ignored: cfg_out=%h locked=%b wacks=%0d expected A5/0/0",
               o_cfg_out, o_locked, wack_cnt - w0);
    end
  endtask

  task automatic test_back_to_back();
    int w0;
    w0 = wack_cnt;
    i_cfg_wen = 1'b1;
    i_cfg_wdata = 8'h11;
    exp_q.push_back(8'h11);
    step();
    i_cfg_wdata = 8'h22;
    exp_q.push_back(8'h22);
    step();
    i_cfg_wen = 1'b0;
    total++;
    if (o_cfg_out !== 8'h22) begin
      bad++;
      $display("FAIL b2b_cfg: cfg_out=%h expected=22", o_cfg_out);
    end
    step();
    total++;
    if (o_cfg_wack !== 1'b0 || wack_cnt - w0 != 2) begin
      bad++;
      $display("FAIL b2b_wack: wack=%b pulses=%0d expected 0 and 2", o_cfg_wack, wack_cnt - w0);
    end
  endtask

  task automatic test_lock();
    int w0;
    w0 = wack_cnt;
    i_cfg_wen = 1'b1;
    i_cfg_wdata = 8'h33;
    i_cfg_lock = 1'b1;
    exp_q.push_back(8'h33);
    step();
    i_cfg_wen = 1'b0;
    i_cfg_lock = 1'b0;
    total++;
    if (o_cfg_out !== 8'h33 || o_locked !== 1'b1) begin
      bad++;
      $display("FAIL lock_same_cycle: cfg_out=%h locked=%b expected 33/1", o_cfg_out, o_locked);
    end
    step();
    i_cfg_wen = 1'b1;
    i_cfg_wdata = 8'h44;
    step();
    i_cfg_wen = 1'b0;
    step();
    total++;
    if (o_cfg_out !== 8'h33 || wack_cnt - w0 != 1 || o_locked !== 1'b1) begin
      bad++;
      $display("FAIL lock_blocks: cfg_out=%h wacks=%0d locked=%b expected 33/1/1",
               o_cfg_out, wack_cnt - w0, o_locked);
    end
  endtask

  task automatic test_reset_midop();
    i_rst = 1'b1;
    step();
    check_zero("midop_reset");
    release_and_wait(0, 8'hA5, 1'b0, 6, 8'hA5, 1'b0, "midop_restart");
  endtask

  initial begin
    @(negedge i_clk);
    test_reset();
    test_stable();
    test_back_to_back();
    test_lock();
    test_reset_midop();
    test_glitch();
    test_forced();
    test_early_access();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d writes never acknowledged expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/la_strapctrl.md
# la_strapctrl

Strap/tie-off configuration controller. After reset it waits for strap inputs (driven by tie-high/tie-low cells or pads) to settle, samples them twice, and publishes a validated configuration word. Software can then override the configuration until a sticky lock is set. It sits between the tie-off/strap cells and the configuration consumers of a block.

## Interface
Parameters:
- N, 8, configuration/strap width (≥1)
- SETTLE, 4, settle-wait cycles before each sample attempt (≥1)
- RETRY, 3, mismatching sample attempts tolerated before forced accept (≥1)
- PROP, "DEFAULT", implementation property string, passed through

Ports:
- clk  input  1  clock; single clock domain
- rst  input  1  synchronous, active-high reset
- strap_in  input  N  raw strap values from tie cells/pads
- cfg_wen  input  1  override write request
- cfg_wdata  input  N  override value
- cfg_lock  input  1  lock request (sticky)
- cfg_out  output  N  current configuration word
- valid  output  1  cfg_out holds a sampled/validated value
- cfg_wack  output  1  one-cycle pulse: override write accepted
- locked  output  1  overrides disabled until reset
- strap_err  output  1  sticky: strap never matched on two consecutive samples; forced accept used

## Operation
- States: SETTLE, CAPTURE, CHECK, RUN.
- Reset (rst=1 at a clk edge): state=SETTLE, settle count=0, retry count=0, shadow=0; cfg_out=0, valid=0, cfg_wack=0, locked=0, strap_err=0. Reset mid-operation, including in RUN or while locked, returns to this state.
- SETTLE: count increments each cycle. When count==SETTLE-1, go to CAPTURE and clear count.
- CAPTURE: shadow<=strap_in, then go to CHECK.
- CHECK: compare strap_in with shadow.
  - Equal: cfg_out<=shadow, valid<=1, go to RUN.
  - Unequal and retry<RETRY-1: retry++, go to SETTLE.
  - Unequal and retry==RETRY-1: cfg_out<=strap_in, valid<=1, strap_err<=1, go to RUN.
- RUN: terminal until reset. strap_in is ignored.
  - cfg_wen=1 and locked=0: cfg_out<=cfg_wdata, cfg_wack pulses on the next cycle.
  - cfg_wen while locked, or in any state other than RUN: ignored, no cfg_wack.
  - cfg_lock=1 in RUN: locked<=1. cfg_lock outside RUN is ignored.
  - cfg_wen and cfg_lock in the same cycle: the write is accepted (with cfg_wack), then locked is set. Both take effect on the same edge.
- valid, locked and strap_err never deassert except through reset.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Stable straps: the first rising edge with rst=0 is cycle 0, and valid rises after edge SETTLE+1. Default: valid is high in cycle SETTLE+2 = 6.
- Each failed attempt adds SETTLE+2 cycles. Worst case, valid rises RETRY·(SETTLE+2) cycles after reset release.
- Override latency: cfg_wen sampled at edge k puts cfg_out=cfg_wdata and cfg_wack=1 in the cycle after edge k. cfg_wack lasts exactly one cycle per accepted write. Back-to-back writes are accepted every cycle.
- Lock latency: cfg_lock sampled at edge k blocks writes sampled at edge k+1 onward.
- Counter widths: settle count is $clog2(SETTLE+1) bits; retry count is $clog2(RETRY+1) bits. Neither counter wraps; each is cleared on its state exit.

## Structure
- Package la_strapctrl_pkg contains:
  - state enum (SETTLE, CAPTURE, CHECK, RUN), 2-bit encoding;
  - width helper functions for the counters.
- One sub-module, la_strapctrl_settle: the parameterized settle counter, with inputs clk, rst, clear, en and output done (count==SETTLE-1).
- The top level holds the FSM, the shadow register, the retry counter, the override/lock logic and the output registers.

## Test plan
- Reset values, then stable straps: with N=8, SETTLE=4, strap_in=8'hA5 constant, release rst. Expect all outputs 0 during reset, valid=1 and cfg_out=8'hA5 in cycle 6, strap_err=0.
- Glitch recovery: strap_in=8'h00 at the CAPTURE edge, then 8'h3C from CHECK onward. Expect one retry, valid in cycle 12 with cfg_out=8'h3C, strap_err=0.
- Forced accept: strap_in toggles 8'h55/8'hAA every cycle, RETRY=3. Expect valid in cycle 18, strap_err=1, and cfg_out equal to the strap_in value at the final CHECK.
- Override and lock: in RUN, write 8'h11 then 8'h22 on consecutive cycles. Expect cfg_out to follow with 1-cycle latency and two cfg_wack pulses. Then assert cfg_wen=1 with 8'h33 and cfg_lock=1 together: expect cfg_out=8'h33 and locked=1. A later write of 8'h44 gives no cfg_wack and cfg_out stays 8'h33.
- Early access ignored: cfg_wen=1 with 8'hFF and cfg_lock=1 held during SETTLE/CAPTURE/CHECK, deasserted on the first RUN cycle. Expect cfg_out equal to the sampled straps, locked=0, no cfg_wack.
- Reset mid-operation: assert rst for 1 cycle while locked in RUN. Expect all outputs 0 on the next cycle and the sampling sequence to restart with a fresh valid at cycle 6.
